// File: rtl/bram_axis_reader_if.sv
// rtl/bram_axis_reader_if.sv - BRAM read port and AXI4-Stream master bundle
interface bram_axis_reader_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) ();
  logic [AWIDTH-1:0] addr_b0;
  logic              ce_b0;
  logic              we_b0;
  logic [DWIDTH-1:0] d_b0;
  logic [DWIDTH-1:0] q_b0;
  logic              m_tvalid;
  logic              m_tready;
  logic [DWIDTH-1:0] m_tdata;
  logic              m_tlast;

  modport master (
    output addr_b0, ce_b0, we_b0, d_b0,
    input  q_b0,
    output m_tvalid, m_tdata, m_tlast,
    input  m_tready
  );

  modport slave (
    input  addr_b0, ce_b0, we_b0, d_b0,
    output q_b0,
    input  m_tvalid, m_tdata, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/bram_axis_reader.sv
// rtl/bram_axis_reader.sv - reads a word count from BRAM address 0 up and streams it out as AXIS
// Define BRAM_OUT_REG_EN for a BRAM with output register: 2-cycle read latency, 3-entry FIFO.
module bram_axis_reader #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int MEM_SIZE = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  output logic               o_idle,
  output logic               o_read,
  output logic               o_done,
  bram_axis_reader_if.master bus
);

`ifdef BRAM_OUT_REG_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
`endif
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [CNT_BIT-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_BIT-1:0] tx_cnt_q, tx_cnt_d;
  logic [LAT-1:0]     pipe_q, pipe_d;
  logic [DWIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [1:0]         fill_q;
  logic [1:0]         inflight;
  logic [2:0]         occ;
  logic               issue, push, pop, last_beat, tvalid;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy counts reads still in the BRAM pipeline so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + 2'(pipe_q[i]);
    end
    occ = 3'(fill_q) + 3'(inflight);
  end

  assign tvalid    = (fill_q != 2'd0);
  assign pop       = tvalid & bus.m_tready;
  assign push      = pipe_q[LAT-1];
  assign last_beat = (tx_cnt_q == cnt_q - CNT_BIT'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          cnt_d    = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? CNT_BIT'(MEM_SIZE) : i_num_cnt;
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = (i_num_cnt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        issue = (rd_cnt_q < cnt_q) &&
                ((occ < 3'(DEPTH)) || ((occ == 3'(DEPTH)) && pop));
        if (issue) rd_cnt_d = rd_cnt_q + CNT_BIT'(1);
        if (pop)   tx_cnt_d = tx_cnt_q + CNT_BIT'(1);
        if (pop && last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Shift the issue flag through the read-latency pipeline; bit LAT-1 is the arriving word.
    pipe_d = LAT'({pipe_q, issue});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      pipe_q   <= pipe_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.q_b0;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 2'd1;
        2'b01:   fill_q <= fill_q - 2'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign o_idle       = (state_q == S_IDLE);
  assign o_read       = (state_q == S_RUN);
  assign o_done       = (state_q == S_DONE);
  assign bus.addr_b0  = rd_cnt_q[AWIDTH-1:0];
  assign bus.ce_b0    = issue;
  assign bus.we_b0    = 1'b0;
  assign bus.d_b0     = '0;
  // Head entry is registered, so data and last stay put while the beat waits for ready.
  assign bus.m_tvalid = tvalid;
  assign bus.m_tdata  = mem_q[rd_ptr_q];
  assign bus.m_tlast  = tvalid & last_beat;

endmodule

// File: tb/tb_bram_axis_reader.sv
// tb/tb_bram_axis_reader.sv - self-checking bench for bram_axis_reader with a scoreboard queue
module tb_bram_axis_reader;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_run = 1'b0;
  logic [30:0] i_num_cnt = '0;
  logic        o_idle, o_read, o_done;

  bram_axis_reader_if #(.DWIDTH(32), .AWIDTH(12)) bus ();

  bram_axis_reader #(.CNT_BIT(31), .DWIDTH(32), .AWIDTH(12), .MEM_SIZE(4096)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .o_idle    (o_idle),
    .o_read    (o_read),
    .o_done    (o_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [4096];
  logic [31:0] q_r1, q_r2;
  always @(posedge clk) begin
    if (bus.ce_b0) q_r1 <= ram[bus.addr_b0];
    q_r2 <= q_r1;
  end
`ifdef BRAM_OUT_REG_EN
  assign bus.q_b0 = q_r2;
`else
  assign bus.q_b0 = q_r1;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int run_n, e0, rd_seen, beats, tv_cnt, done_cnt, done_cyc, last_edge;
  logic        hold_pend = 1'b0;
  logic [32:0] hold_val;
  logic [32:0] exp_q [$];
  logic [32:0] got;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = ($urandom_range(0, 99) >= 30);
        default: bus.m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled mid-cycle, so valid&ready here means a handshake at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ce_b0) begin
        check("rd_addr", 64'(bus.addr_b0), 64'(rd_seen[11:0]));
        check("rd_in_range", 64'(rd_seen < run_n), 64'(1));
        rd_seen++;
      end
      if (bus.m_tvalid) tv_cnt++;
      if (hold_pend) begin
        check("valid_hold", 64'(bus.m_tvalid), 64'(1));
        check("data_hold", 64'({bus.m_tlast, bus.m_tdata}), 64'(hold_val));
      end
      hold_pend = bus.m_tvalid && !bus.m_tready;
      hold_val  = {bus.m_tlast, bus.m_tdata};
      if (bus.m_tvalid && bus.m_tready) begin
        check("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check("beat_data_last", 64'({bus.m_tlast, bus.m_tdata}), 64'(got));
        end
        beats++;
        if (bus.m_tlast) last_edge = cyc + 1;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_run(input int n);
    @(posedge clk);
    #1;
    i_run     = 1'b1;
    i_num_cnt = 31'(n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), ram[i]});
    run_n = n; rd_seen = 0; beats = 0; tv_cnt = 0; done_cnt = 0;
    done_cyc = -1; last_edge = -1;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    i_run     = 1'b0;
    i_num_cnt = 31'h5a5;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int c = 0;
    while (done_cnt == 0 && c < limit) begin
      @(negedge clk);
      #2;
      c++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    @(negedge clk);
    #2;
    check({tag, "_idle_after_done"}, 64'({o_idle, o_read, o_done}), 64'(3'b100));
  endtask

  task automatic post_checks(input string tag, input int n);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_beats"}, 64'(beats), 64'(n));
    check({tag, "_reads"}, 64'(rd_seen), 64'(n));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_o_idle"}, 64'(o_idle), 64'(1));
    check({tag, "_o_read"}, 64'(o_read), 64'(0));
    check({tag, "_o_done"}, 64'(o_done), 64'(0));
    check({tag, "_ce_we"}, 64'({bus.ce_b0, bus.we_b0}), 64'(0));
    check({tag, "_addr"}, 64'(bus.addr_b0), 64'(0));
    check({tag, "_d_b0"}, 64'(bus.d_b0), 64'(0));
    check({tag, "_tvalid_tlast"}, 64'({bus.m_tvalid, bus.m_tlast}), 64'(0));
    check({tag, "_tdata"}, 64'(bus.m_tdata), 64'(0));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'(i);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    reset_n = 1'b1;

    rdy_mode = 0;
    start_run(3840);
    wait_done("full", 8000);
    post_checks("full", 3840);
    check("full_last_edge", 64'(last_edge - e0), 64'(3840 + LAT + 1));
    check("full_done_cycle", 64'(done_cyc), 64'(last_edge));

    rdy_mode = 1;
    start_run(3840);
    wait_done("rand", 20000);
    post_checks("rand", 3840);

    rdy_mode = 0;
    start_run(1);
    wait_done("one", 100);
    post_checks("one", 1);
    check("one_last_edge", 64'(last_edge - e0), 64'(1 + LAT + 1));

    start_run(0);
    wait_done("zero", 100);
    check("zero_done_cycle", 64'(done_cyc), 64'(e0));
    check("zero_no_valid", 64'(tv_cnt), 64'(0));
    check("zero_no_reads", 64'(rd_seen), 64'(0));
    check("zero_done_pulses", 64'(done_cnt), 64'(1));

    start_run(4096);
    repeat (100) @(posedge clk);
    #1;
    i_run = 1'b1;
    i_num_cnt = 31'd5;
    @(posedge clk);
    #1;
    i_run = 1'b0;
    wait_done("depth", 9000);
    post_checks("depth", 4096);
    check("depth_last_edge", 64'(last_edge - e0), 64'(4096 + LAT + 1));

    rdy_mode = 2;
    start_run(8);
    repeat (50) @(negedge clk);
    #2;
    check("stall_reads", 64'(rd_seen), 64'(DEPTH));
    check("stall_beats", 64'(beats), 64'(0));
    check("stall_valid", 64'(bus.m_tvalid), 64'(1));
    rdy_mode = 0;
    wait_done("stall", 200);
    post_checks("stall", 8);

    start_run(3840);
    for (int c = 0; c < 1000 && beats < 100; c++) begin
      @(negedge clk);
      #2;
    end
    check("mid_reached_100", 64'(beats >= 100), 64'(1));
    reset_n = 1'b0;
    #1;
    reset_checks("mid");
    exp_q.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    start_run(16);
    wait_done("rerun", 200);
    post_checks("rerun", 16);
    check("rerun_last_edge", 64'(last_edge - e0), 64'(16 + LAT + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_axis_reader.md
# bram_axis_reader

Reads `i_num_cnt` consecutive words from a true dual-port BRAM port, starting at address 0, and emits them in order as an AXI4-Stream master. `m_tlast` marks the final beat. It is the BRAM-to-stream (MM2S-style) end of the data mover path. It drives the data-mover side of a `true_dpbram` port, and its stream output feeds a downstream core or DMA. Full throughput is one beat per cycle; `m_tready` backpressure is absorbed without dropping or repeating data.

## Interface
- `CNT_BIT`, 31: width of `i_num_cnt`.
- `DWIDTH`, 32: data width of the BRAM and the stream.
- `AWIDTH`, 12: BRAM address width.
- `MEM_SIZE`, 4096: BRAM depth; the legal range is `i_num_cnt` <= `MEM_SIZE`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_run`  in  1  start pulse; sampled only in IDLE.
- `i_num_cnt`  in  CNT_BIT  number of words to transfer; latched when `i_run` is accepted.
- `o_idle`  out  1  high in IDLE.
- `o_read`  out  1  high in RUN.
- `o_done`  out  1  one-cycle pulse in DONE.
- `addr_b0`  out  AWIDTH  BRAM read address.
- `ce_b0`  out  1  BRAM chip enable; high only on a read issue.
- `we_b0`  out  1  tied 0.
- `d_b0`  out  DWIDTH  tied 0.
- `q_b0`  in  DWIDTH  BRAM read data; valid 1 cycle after `ce_b0`.
- `m_tvalid`  out  1  AXIS valid.
- `m_tready`  in  1  AXIS ready.
- `m_tdata`  out  DWIDTH  AXIS data.
- `m_tlast`  out  1  high on the beat with index `i_num_cnt`-1.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when `i_run`=1 and the latched count is nonzero.
  - IDLE -> DONE when `i_run`=1 and `i_num_cnt`=0. No read is issued and no beat is sent.
  - RUN -> DONE on the handshake (`m_tvalid` & `m_tready`) of the last beat.
  - DONE -> IDLE unconditionally after 1 cycle.
- `i_run` is ignored in RUN and DONE. `i_num_cnt` changes after the start have no effect.
- Counters:
  - `rd_cnt` counts issued reads. It is compared against the latched count, and `addr_b0` = `rd_cnt`[AWIDTH-1:0].
  - `tx_cnt` counts handshaken beats.
  - Both clear on entry to RUN.
- Output buffer: a 2-entry FIFO holds returned `q_b0` words.
  - `occ` = buffered entries + reads in flight.
  - A read is issued in RUN when `rd_cnt` < count and either `occ` < 2, or `occ` = 2 and a pop occurs in the same cycle.
  - The FIFO never overflows and there are no bubbles while `m_tready` is held at 1.
- AXIS rules:
  - Once `m_tvalid` rises, `m_tdata` and `m_tlast` stay stable until the handshake.
  - `m_tvalid` never depends combinationally on `m_tready`.
- `m_tlast` = (`tx_cnt` == count-1) on the head beat.
- Reset (asynchronous, any state, including mid-transfer):
  - FSM goes to IDLE; counters and FIFO clear.
  - `o_idle`=1, all other outputs are 0, and `addr_b0`=0.
  - Any partial transfer is abandoned.

## Timing
- Reset values: `o_idle`=1; `o_read`=`o_done`=`ce_b0`=`we_b0`=`m_tvalid`=`m_tlast`=0; `addr_b0`=0; `d_b0`=0; `m_tdata`=0.
- Cycle-level sequence, counting from edge E0 at which `i_run` is sampled:
  - State is RUN after E0.
  - `ce_b0`=1, `addr_b0`=0 in the cycle after E0.
  - `q_b0` is valid after E1 and enters the FIFO at E2.
  - `m_tvalid`=1 after E2, giving a first-beat latency of 2 cycles.
- With `m_tready`=1 throughout, N words take N+2 cycles from E0 to the last handshake. `o_done` is high in the following cycle, and `o_idle` is high one cycle after that.
- If `m_tready` is low for k cycles, the stream stalls k cycles. At most 2 reads are outstanding, and reads stop until a pop.

## Configuration
- `BRAM_OUT_REG_EN` defined:
  - The BRAM output register is used, so read latency is 2 cycles.
  - Capacity becomes 3 (FIFO depth 3, `occ` < 3 rule).
  - First-beat latency is 3 cycles and N words take N+3 cycles; throughput is still 1 beat/cycle.
- `BRAM_OUT_REG_EN` undefined: 1-cycle read latency as specified above.

## Test plan
- Preload BRAM0 with `ram[i]`=i, i=0..3839; `i_num_cnt`=3840; `m_tready`=1 -> 3840 beats with `m_tdata`=0..3839 in order, `m_tlast` only on 3839, the last handshake at E0+3842, and one `o_done` pulse.
- Same data, `m_tready` toggling 1/0 with a random 30% low rate -> identical data sequence with no drop or duplicate, and `m_tdata` stable while `m_tvalid`=1 and `m_tready`=0.
- `i_num_cnt`=1 -> a single beat with `m_tdata`=`ram[0]` and `m_tlast`=1; `i_num_cnt`=0 -> no `m_tvalid`, and `o_done` in the cycle after `i_run`.
- `i_num_cnt`=4096 (full depth) -> `addr_b0` reaches 4095 and never wraps to 0; 4096 beats are sent.
- Hold `m_tready`=0 for 50 cycles after start -> `ce_b0` pulses at most 2 times (3 with `BRAM_OUT_REG_EN`), and the stream then resumes correctly.
- Assert `reset_n`=0 mid-transfer at beat 100, then re-run with `i_num_cnt`=16 -> outputs at reset values immediately, and the re-run sends 0..15 with `m_tlast` on 15.
